// File: rtl/spike_event_packer.sv
`default_nettype none
// ============================================================================
// Module      : spike_event_packer
// Description : Turns LIF spike onsets into {timestamp, membrane} packets,
//               queues them, and streams them out as valid/ready bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_event_packer #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike,
    input  logic [7:0]       membrane_state,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic [7:0]       overflow_cnt
);

    localparam int               c_PTR_W   = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] c_FULL    = LVL_W'(DEPTH);
    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_SEND_TS = 2'd1;
    localparam logic [1:0]       c_SEND_ST = 2'd2;

    logic [7:0]         r_ts;
    logic               r_spike_q;
    logic [15:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [7:0]         r_ovf;
    logic [1:0]         r_state;

    logic        w_event;
    logic        w_full;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic [15:0] w_head;

    // A full FIFO drops the event even if the head pops on the same edge.
    assign w_event = spike & ~r_spike_q;
    assign w_full  = (r_level == c_FULL);
    assign w_push  = w_event & ~w_full;
    assign w_drop  = w_event & w_full;
    assign w_pop   = (r_state == c_SEND_ST) & out_ready;

    // Output bytes come only from FSM state and the FIFO head.
    always_comb begin
        w_head    = r_mem[r_rd_ptr];
        out_valid = (r_state != c_IDLE);
        out_data  = 8'h00;
        case (r_state)
            c_SEND_TS: out_data = w_head[15:8];
            c_SEND_ST: out_data = w_head[7:0];
            default:   out_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_ts, membrane_state};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_ts      <= 8'd0;
            r_spike_q <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_ovf     <= 8'd0;
            r_state   <= c_IDLE;
        end else begin
            r_ts      <= r_ts + 8'd1;
            r_spike_q <= spike;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase

            if (w_drop && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 8'd1;
            end

            case (r_state)
                c_IDLE: begin
                    if (r_level != '0) begin
                        r_state <= c_SEND_TS;
                    end
                end
                c_SEND_TS: begin
                    if (out_ready) begin
                        r_state <= c_SEND_ST;
                    end
                end
                c_SEND_ST: begin
                    // Chain straight into the next packet when one is waiting.
                    if (out_ready) begin
                        r_state <= (r_level > LVL_W'(1)) ? c_SEND_TS : c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign fifo_level   = r_level;
    assign overflow_cnt = r_ovf;

endmodule
`default_nettype wire
